// File: rtl/generator_host_bridge.sv
// generator_host_bridge: loads a seed batch into the generator, kicks it, then drains its features as a valid/ready stream.
// Define GEN_HOST_BRIDGE_LFSR_EN to source seeds from an internal LFSR instead of the seed_in stream.
module generator_host_bridge #(
   parameter int SEED_COUNT     = 64,
   parameter int FEATURE_COUNT  = 128,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        seed_in_valid,
   output logic        seed_in_ready,
   input  logic [15:0] seed_in_data,
   output logic        gen_seed_wr_en,
   output logic [15:0] gen_seed_wr_data,
   input  logic        gen_seed_full,
   input  logic [6:0]  gen_seed_level,
   output logic        gen_start,
   input  logic        gen_busy,
   input  logic        gen_done,
   output logic        gen_feature_rd_en,
   input  logic [15:0] gen_feature_rd_data,
   input  logic        gen_feature_rd_valid,
   input  logic        gen_feature_empty,
   output logic        feat_out_valid,
   input  logic        feat_out_ready,
   output logic [15:0] feat_out_data,
   output logic        feat_out_last,
   output logic        busy,
   output logic        done,
   output logic        timeout_err
);
   localparam logic [7:0]  SC_L  = 8'(SEED_COUNT);
   localparam logic [7:0]  FC_L  = 8'(FEATURE_COUNT);
   localparam logic [7:0]  FC_M1 = 8'(FEATURE_COUNT - 1);
   localparam logic [31:0] TO_M1 = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_KICK, S_WAIT, S_DRAIN, S_FIN} state_t;

   state_t      r_state;
   logic [6:0]  r_need, r_wr;
   logic [7:0]  r_iss, r_idx;
   logic [31:0] r_wd;
   logic        r_pend, r_start, r_fv, r_err;
   logic [15:0] r_fd;
   logic        w_wr_en, w_rd_en, w_pop, w_room, w_expire, w_accept;
   logic [6:0]  w_wr_nxt, w_need;
   logic [15:0] w_seed;

`ifdef GEN_HOST_BRIDGE_LFSR_EN
   logic [15:0] r_lfsr;
   logic        w_unused;
   assign w_unused      = ^{seed_in_valid, seed_in_data};
   assign seed_in_ready = 1'b0;
   assign w_wr_en       = r_state == S_FILL && !gen_seed_full && r_wr < r_need;
   assign w_seed        = r_lfsr;
   // Free-running across runs; only reset reloads the seed value.
   always_ff @(posedge clk)
      if (rst) r_lfsr <= 16'hACE1;
      else if (w_wr_en) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`else
   assign seed_in_ready = r_state == S_FILL && !gen_seed_full && r_wr < r_need;
   assign w_wr_en       = seed_in_valid && seed_in_ready;
   assign w_seed        = seed_in_data;
`endif

   assign gen_seed_wr_en    = w_wr_en;
   assign gen_seed_wr_data  = w_wr_en ? w_seed : 16'd0;
   assign w_wr_nxt          = r_wr + 7'(w_wr_en);
   assign w_need            = ({1'b0, gen_seed_level} >= SC_L) ? 7'd0 : 7'(SC_L - {1'b0, gen_seed_level});
   assign w_accept          = run && !gen_busy && gen_feature_empty;
   assign w_room            = !r_fv || feat_out_ready;
   assign w_rd_en           = r_state == S_DRAIN && !gen_feature_empty && !r_pend && r_iss < FC_L && w_room;
   assign w_pop             = r_fv && feat_out_ready;
   assign w_expire          = r_wd == TO_M1;
   assign gen_feature_rd_en = w_rd_en;
   assign gen_start         = r_start;
   assign feat_out_valid    = r_fv;
   assign feat_out_data     = r_fd;
   assign feat_out_last     = r_fv && r_idx == FC_M1;
   assign busy              = r_state != S_IDLE;
   assign done              = r_state == S_FIN;
   assign timeout_err       = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_need  <= '0;
         r_wr    <= '0;
         r_iss   <= '0;
         r_idx   <= '0;
         r_wd    <= '0;
         r_pend  <= 1'b0;
         r_start <= 1'b0;
         r_fv    <= 1'b0;
         r_fd    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_wd   <= (r_state == S_KICK || r_state == S_WAIT) ? r_wd + 32'd1 : 32'd0;
         r_wr   <= w_wr_nxt;
         r_iss  <= r_iss + 8'(w_rd_en);
         r_idx  <= r_idx + 8'(w_pop);
         r_pend <= w_rd_en || (r_pend && !gen_feature_rd_valid);
         if (r_state == S_DRAIN && gen_feature_rd_valid) begin
            r_fd <= gen_feature_rd_data;
            r_fv <= 1'b1;
         end else if (w_pop) r_fv <= 1'b0;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_state <= S_FILL;
               r_need  <= w_need;
               r_err   <= 1'b0;
               r_wr    <= '0;
               r_iss   <= '0;
               r_idx   <= '0;
            end
            S_FILL: if (w_wr_nxt == r_need) begin
               r_state <= S_KICK;
               r_start <= 1'b1;
            end
            // Hold start until busy is seen; the seed level lags writes by a cycle.
            S_KICK: if (gen_busy) begin
               r_state <= S_WAIT;
               r_start <= 1'b0;
            end else if (w_expire) begin
               r_state <= S_IDLE;
               r_start <= 1'b0;
               r_err   <= 1'b1;
            end
            S_WAIT: if (gen_done) r_state <= S_DRAIN;
               else if (w_expire) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end
            S_DRAIN: if (w_pop && feat_out_last) r_state <= S_FIN;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_generator_host_bridge.sv
// tb_generator_host_bridge: randomized bench with a queue-based generator model and expected-stream scoreboard.
module tb_generator_host_bridge;
   localparam int SC = 64, FC = 128, TO = 50, LAT = 5;

   logic        clk = 1'b0, rst, run;
   logic        seed_in_valid, seed_in_ready;
   logic [15:0] seed_in_data;
   logic        gen_seed_wr_en, gen_seed_full, gen_start, gen_busy, gen_done;
   logic [15:0] gen_seed_wr_data, gen_feature_rd_data, feat_out_data;
   logic [6:0]  gen_seed_level;
   logic        gen_feature_rd_en, gen_feature_rd_valid, gen_feature_empty;
   logic        feat_out_valid, feat_out_ready, feat_out_last, busy, done, timeout_err;

   always #5 clk = ~clk;

   generator_host_bridge #(.SEED_COUNT(SC), .FEATURE_COUNT(FC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .run(run),
      .seed_in_valid(seed_in_valid), .seed_in_ready(seed_in_ready), .seed_in_data(seed_in_data),
      .gen_seed_wr_en(gen_seed_wr_en), .gen_seed_wr_data(gen_seed_wr_data),
      .gen_seed_full(gen_seed_full), .gen_seed_level(gen_seed_level),
      .gen_start(gen_start), .gen_busy(gen_busy), .gen_done(gen_done),
      .gen_feature_rd_en(gen_feature_rd_en), .gen_feature_rd_data(gen_feature_rd_data),
      .gen_feature_rd_valid(gen_feature_rd_valid), .gen_feature_empty(gen_feature_empty),
      .feat_out_valid(feat_out_valid), .feat_out_ready(feat_out_ready), .feat_out_data(feat_out_data),
      .feat_out_last(feat_out_last), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Generator model: seed FIFO occupancy, feature FIFO contents, busy/done timing.
   int          sq = 0, g_timer = 0, ff_at = -1, ff_left = 0, ncyc = 0, seed_idx = 0;
   logic [15:0] fq[$], exp_out[$];
   bit          m_busy = 0, m_done = 0, m_rv = 0, g_active = 0, nodone = 0, rand_feat = 0;
   logic [15:0] m_rd = '0, lfsr_ref = 16'hACE1, hold_d = '0;
   bit          hold = 0, rst_v = 1, run_v = 0;
   int          vmode = 0, rmode = 0;
   int          writes, first_wr, last_wr, start_cyc, first_start, out_cnt, done_cnt, err_cyc;

   task automatic begin_run();
      writes = 0; first_wr = -1; last_wr = -1; start_cyc = 0; first_start = -1;
      out_cnt = 0; done_cnt = 0; err_cyc = -1; seed_idx = 0;
   endtask

   task automatic cyc();
      logic [15:0] w;
      bit          rd_now;
      @(negedge clk);
      rst                  = rst_v;
      run                  = run_v;
      gen_seed_full        = sq >= SC || ff_left > 0;
      gen_seed_level       = 7'(sq);
      gen_busy             = m_busy;
      gen_done             = m_done;
      gen_feature_empty    = fq.size() == 0;
      gen_feature_rd_valid = m_rv;
      gen_feature_rd_data  = m_rd;
      seed_in_valid        = vmode == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
      seed_in_data         = 16'(seed_idx);
      feat_out_ready       = rmode == 0 ? 1'b1 : rmode == 1 ? ((ncyc / 3) % 2 == 0) : 1'($urandom_range(0, 1));
      #2;
      ncyc++;
      if (gen_seed_full) check("rdy_full", seed_in_ready, 0);
      if (gen_seed_wr_en) begin
         check("wr_full", gen_seed_full, 0);
`ifdef GEN_HOST_BRIDGE_LFSR_EN
         check("wr_data", gen_seed_wr_data, lfsr_ref);
         lfsr_ref = {lfsr_ref[14:0], ^(lfsr_ref & 16'hB400)};
`else
         check("wr_hs", seed_in_valid && seed_in_ready, 1);
         check("wr_data", gen_seed_wr_data, 16'(seed_idx));
`endif
         seed_idx++; sq++; writes++;
         if (first_wr < 0) first_wr = ncyc;
         last_wr = ncyc;
      end
      rd_now = gen_feature_rd_en;
      if (rd_now) begin
         check("rd_outst", m_rv, 0);
         check("rd_empty", fq.size() == 0, 0);
      end
      if (hold) begin
         check("hold_v", feat_out_valid, 1);
         check("hold_d", feat_out_data, hold_d);
      end
      hold   = feat_out_valid && !feat_out_ready && !rst;
      hold_d = feat_out_data;
      if (feat_out_valid && feat_out_ready) begin
         if (exp_out.size() == 0) check("extra_word", 1, 0);
         else begin
            w = exp_out.pop_front();
            check("feat_data", feat_out_data, w);
            check("feat_last", feat_out_last, exp_out.size() == 0);
         end
         out_cnt++;
      end
      if (done) done_cnt++;
      if (gen_start) begin
         start_cyc++;
         if (first_start < 0) first_start = ncyc;
      end
      if (timeout_err && err_cyc < 0) err_cyc = ncyc;
      m_rv = rd_now && fq.size() > 0;
      if (m_rv) m_rd = fq.pop_front();
      m_done = 0;
      if (g_active && g_timer > 0) begin
         g_timer--;
         if (g_timer == 0) begin
            g_active = 0;
            if (!nodone) begin
               m_done = 1;
               for (int i = 0; i < FC; i++) begin
                  w = rand_feat ? 16'($urandom) : 16'(16'h1000 + i);
                  fq.push_back(w);
                  exp_out.push_back(w);
               end
            end
         end
      end
      if (gen_start && !g_active) begin
         g_active = 1; g_timer = LAT; sq = 0;
      end
      m_busy = g_active;
      if (ff_left > 0) ff_left--;
      if (ff_at >= 0 && writes == ff_at) begin
         ff_left = 5; ff_at = -1;
      end
   endtask

   task automatic do_run(output int run_cyc);
      int n = 0;
      run_v = 1;
      cyc();
      run_cyc = ncyc;
      run_v = 0;
      err_cyc = -1;
      while (done_cnt == 0 && err_cyc < 0 && n < 3000) begin
         cyc();
         n++;
      end
      if (n >= 3000) check("run_budget", n, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sready"}, seed_in_ready, 0);
      check({tag, "_wr_en"}, gen_seed_wr_en, 0);
      check({tag, "_wr_data"}, gen_seed_wr_data, 0);
      check({tag, "_start"}, gen_start, 0);
      check({tag, "_rd_en"}, gen_feature_rd_en, 0);
      check({tag, "_fvalid"}, feat_out_valid, 0);
      check({tag, "_fdata"}, feat_out_data, 0);
      check({tag, "_flast"}, feat_out_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_terr"}, timeout_err, 0);
   endtask

   initial begin
      int rc, n;
      begin_run();
      rst_v = 1;
      repeat (3) cyc();
      check_reset_outputs("reset");
      rst_v = 0;
      cyc();

      // Nominal run: level 0, continuous seeds, always-ready sink.
      begin_run();
      do_run(rc);
      check("t1_first_wr", first_wr, rc + 1);
      check("t1_writes", writes, SC);
      check("t1_consec", last_wr - first_wr + 1, SC);
      check("t1_kick_after_fill", first_start, last_wr + 1);
      check("t1_start_cycles", start_cyc, 2);
      check("t1_out_cnt", out_cnt, FC);
      check("t1_done", done_cnt, 1);
      repeat (3) cyc();
      check("t1_done_once", done_cnt, 1);
      check("t1_idle", busy, 0);

      // Pre-filled seed FIFO reduces the batch.
      begin_run();
      sq = 10;
      cyc();
      do_run(rc);
      check("t2_writes", writes, SC - 10);
      check("t2_out_cnt", out_cnt, FC);
      repeat (2) cyc();

      // FIFO full for 5 cycles mid-fill.
      begin_run();
      ff_at = 20;
      do_run(rc);
      check("t3_writes", writes, SC);
      check("t3_span", last_wr - first_wr + 1, SC + 5);
      check("t3_done", done_cnt, 1);
      repeat (2) cyc();

      // Bursty seeds, sink toggling every 3 cycles, random features.
      begin_run();
      vmode = 1; rmode = 1; rand_feat = 1;
      do_run(rc);
      check("t4_writes", writes, SC);
      check("t4_out_cnt", out_cnt, FC);
      check("t4_left", exp_out.size(), 0);
      vmode = 0; rmode = 2;
      repeat (2) cyc();

      // Generator never finishes: watchdog expires 50 cycles after kick.
      begin_run();
      nodone = 1;
      do_run(rc);
      check("t5_err_time", err_cyc - first_start, TO);
      check("t5_err", timeout_err, 1);
      check("t5_idle", busy, 0);
      check("t5_no_done", done_cnt, 0);
      nodone = 0;
      cyc();
      begin_run();
      do_run(rc);
      check("t5_err_clr", err_cyc, 32'hFFFF_FFFF);
      check("t5_rerun_done", done_cnt, 1);
      check("t5_rerun_out", out_cnt, FC);
      repeat (2) cyc();

      // Reset in the middle of the drain.
      begin_run();
      rmode = 0;
      run_v = 1;
      cyc();
      run_v = 0;
      n = 0;
      while (out_cnt < 40 && n < 3000) begin
         cyc();
         n++;
      end
      check("t6_reach40", out_cnt, 40);
      rst_v = 1;
      cyc();
      rst_v = 0;
      exp_out.delete();
      hold = 0;
      cyc();
      check_reset_outputs("t6");
      check("t6_fifo_nonempty", fq.size() > 0, 1);
      run_v = 1;
      repeat (3) begin
         cyc();
         check("t6_reject", busy, 0);
      end
      run_v = 0;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
